// File: rtl/bcd_step_counter.sv
// bcd_step_counter: registered decade (0-9) up/down stepping source for a
// 4-to-10 decoder. Supports synchronous parallel load with range checking,
// a wrap-carry pulse for cascading further digits, and an optional prescaler.
// Optional feature macro: BCD_STEP_PRESCALER_EN (adds a PRESCALE_DIV prescaler;
// without it every enabled, non-load cycle is a step).
module bcd_step_counter #(
    parameter int PRESCALE_DIV = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [3:0] i_load_data,
    output logic [3:0] o_data,
    output logic       o_step,
    output logic       o_carry,
    output logic       o_load_err
);

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Reject out-of-range divider values at elaboration time rather than
    // silently building a prescaler with the wrong period.
    if (PRESCALE_DIV < 2 || PRESCALE_DIV > 65535) begin : g_bad_div
        $error("bcd_step_counter: PRESCALE_DIV must be in 2..65535");
    end

    logic [3:0] data_reg, data_next;
    logic       step_reg, step_next;
    logic       carry_reg, carry_next;
    logic       load_err_reg, load_err_next;
    logic       tick;

`ifdef BCD_STEP_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

    logic [PW-1:0] presc_reg, presc_next;

    assign tick = (presc_reg == PRESC_LAST);

    // Prescaler next count: any load (good or bad) consumes the period,
    // disabled cycles freeze it, enabled cycles advance and wrap on the tick.
    always_comb begin
        presc_next = presc_reg;
        if (i_load) begin
            presc_next = '0;
        end else if (i_en) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
        end
    end

    // Prescaler count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end
`else
    // Without the prescaler every enabled cycle carries a tick.
    assign tick = 1'b1;
`endif

    // Next digit and event pulses: load beats step, step beats hold.
    // Wraps are explicit compares so the digit can never reach 10-15.
    always_comb begin
        data_next     = data_reg;
        step_next     = 1'b0;
        carry_next    = 1'b0;
        load_err_next = 1'b0;
        if (i_load) begin
            if (i_load_data <= DIGIT_MAX) begin
                data_next = i_load_data;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (i_en && tick) begin
            step_next = 1'b1;
            if (i_up) begin
                if (data_reg == DIGIT_MAX) begin
                    data_next  = 4'd0;
                    carry_next = 1'b1;
                end else begin
                    data_next = data_reg + 4'd1;
                end
            end else begin
                if (data_reg == 4'd0) begin
                    data_next  = DIGIT_MAX;
                    carry_next = 1'b1;
                end else begin
                    data_next = data_reg - 4'd1;
                end
            end
        end
    end

    // Output registers; every output comes straight from a flop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg     <= 4'd0;
            step_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            data_reg     <= data_next;
            step_reg     <= step_next;
            carry_reg    <= carry_next;
            load_err_reg <= load_err_next;
        end
    end

    assign o_data     = data_reg;
    assign o_step     = step_reg;
    assign o_carry    = carry_reg;
    assign o_load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_step_counter.sv
// tb_bcd_step_counter: directed self-checking bench for bcd_step_counter.
// Build with BCD_STEP_PRESCALER_EN defined to exercise the prescaler variant.
module tb_bcd_step_counter;

    localparam int DIV = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_up = 1'b1;
    logic       i_load = 1'b0;
    logic [3:0] i_load_data = 4'd0;
    logic [3:0] o_data;
    logic       o_step;
    logic       o_carry;
    logic       o_load_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_no   = 0;

    bcd_step_counter #(.PRESCALE_DIV(DIV)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_up        (i_up),
        .i_load      (i_load),
        .i_load_data (i_load_data),
        .o_data      (o_data),
        .o_step      (o_step),
        .o_carry     (o_carry),
        .o_load_err  (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input int d, input int s, input int c, input int e);
        check_eq({tag, ".data"},  int'(o_data),     d);
        check_eq({tag, ".step"},  int'(o_step),     s);
        check_eq({tag, ".carry"}, int'(o_carry),    c);
        check_eq({tag, ".err"},   int'(o_load_err), e);
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick_clk();
        @(posedge i_clk);
        #1;
        cyc_no++;
        $display("cyc %0d en=%0b up=%0b load=%0b ld=%0d -> data=%0d step=%0b carry=%0b err=%0b",
                 cyc_no, i_en, i_up, i_load, i_load_data, o_data, o_step, o_carry, o_load_err);
    endtask

    // Short asynchronous reset pulse, checked while reset is still low.
    task automatic pulse_reset(input string tag);
        i_rst_n = 1'b0;
        #2;
        expect_out(tag, 0, 0, 0, 0);
        #2;
        i_rst_n = 1'b1;
    endtask

    initial begin
        #12;
        expect_out("reset", 0, 0, 0, 0);
        i_rst_n = 1'b1;

`ifndef BCD_STEP_PRESCALER_EN
        // Count up 12 cycles: 1..9,0,1,2, carry only on 9->0.
        i_en = 1'b1;
        i_up = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick_clk();
            expect_out($sformatf("up%0d", k), k % 10, 1, (k % 10 == 0) ? 1 : 0, 0);
        end

        // Reset mid-count, then count down: 9,8,7 with carry on 0->9.
        pulse_reset("rst_mid");
        i_up = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            expect_out($sformatf("dn%0d", k), 10 - k, 1, (k == 1) ? 1 : 0, 0);
        end

        // Load wins over an enabled step.
        i_up = 1'b1;
        i_load = 1'b1; i_load_data = 4'd4;
        tick_clk(); expect_out("ld4", 4, 0, 0, 0);
        i_load_data = 4'd7;
        tick_clk(); expect_out("ld7", 7, 0, 0, 0);
        i_load = 1'b0;
        tick_clk(); expect_out("after_ld7", 8, 1, 0, 0);

        // Out-of-range loads keep the digit and flag an error each cycle.
        i_load = 1'b1; i_load_data = 4'd3;
        tick_clk(); expect_out("ld3", 3, 0, 0, 0);
        i_load_data = 4'd12;
        tick_clk(); expect_out("ld12", 3, 0, 0, 1);
        i_load_data = 4'd15;
        tick_clk(); expect_out("ld15", 3, 0, 0, 1);
        i_load = 1'b0; i_en = 1'b0;
        tick_clk(); expect_out("err_clear", 3, 0, 0, 0);
        i_load = 1'b1; i_load_data = 4'd15;
        tick_clk(); expect_out("ld15_noen", 3, 0, 0, 1);
        i_load = 1'b0;

        // Hold with enable low.
        for (int k = 1; k <= 2; k++) begin
            tick_clk();
            expect_out($sformatf("hold%0d", k), 3, 0, 0, 0);
        end

        // Boundary loads and direction changes around the wrap.
        i_en = 1'b1;
        i_load = 1'b1; i_load_data = 4'd0;
        tick_clk(); expect_out("ld0", 0, 0, 0, 0);
        i_load = 1'b0; i_up = 1'b0;
        tick_clk(); expect_out("wrap_dn", 9, 1, 1, 0);
        i_up = 1'b1;
        tick_clk(); expect_out("wrap_up", 0, 1, 1, 0);
        tick_clk(); expect_out("up_from0", 1, 1, 0, 0);
        i_load = 1'b1; i_load_data = 4'd9;
        tick_clk(); expect_out("ld9", 9, 0, 0, 0);
        i_load_data = 4'd10;
        tick_clk(); expect_out("ld10", 9, 0, 0, 1);
        i_load = 1'b0; i_up = 1'b0;
        tick_clk(); expect_out("dn_from9", 8, 1, 0, 0);
`else
        // Steps every DIV enabled cycles: advances at cycles 4,8,12,16.
        i_en = 1'b1;
        i_up = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick_clk();
            expect_out($sformatf("ps%0d", k), k / DIV, (k % DIV == 0) ? 1 : 0, 0, 0);
        end
        // Six more cycles: step at the 4th, prescaler then at 2.
        for (int k = 1; k <= 6; k++) begin
            tick_clk();
            expect_out($sformatf("pre_pause%0d", k), 4 + k / DIV, (k == 4) ? 1 : 0, 0, 0);
        end
        // Three disabled cycles delay the next step by exactly three.
        i_en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            expect_out($sformatf("pause%0d", k), 5, 0, 0, 0);
        end
        i_en = 1'b1;
        tick_clk(); expect_out("resume1", 5, 0, 0, 0);
        tick_clk(); expect_out("resume2", 6, 1, 0, 0);

        // Load coinciding with the tick: load wins, the tick is consumed.
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            expect_out($sformatf("to_tick%0d", k), 6, 0, 0, 0);
        end
        i_load = 1'b1; i_load_data = 4'd2;
        tick_clk(); expect_out("ld_on_tick", 2, 0, 0, 0);
        i_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            expect_out($sformatf("post_ld%0d", k), (k == 4) ? 3 : 2, (k == 4) ? 1 : 0, 0, 0);
        end

        // Reset at count 6, prescaler 2; first step needs a full period.
        i_load = 1'b1; i_load_data = 4'd6;
        tick_clk(); expect_out("ld6", 6, 0, 0, 0);
        i_load = 1'b0;
        tick_clk(); tick_clk();
        expect_out("at6_p2", 6, 0, 0, 0);
        pulse_reset("ps_rst");
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            expect_out($sformatf("post_rst%0d", k), (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0, 0);
        end

        // Wrap carry with the prescaler.
        i_load = 1'b1; i_load_data = 4'd9;
        tick_clk(); expect_out("ld9", 9, 0, 0, 0);
        i_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            expect_out($sformatf("wrap%0d", k), (k == 4) ? 0 : 9, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0);
        end

        // A rejected load also restarts the prescaler period.
        tick_clk(); tick_clk();
        i_load = 1'b1; i_load_data = 4'd11;
        tick_clk(); expect_out("ld11", 0, 0, 0, 1);
        i_load = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick_clk();
            expect_out($sformatf("post_err%0d", k), (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
